// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time KMP table builders for seq_detector_param.
// Optional match counter is controlled by the SEQ_DET_COUNT_EN macro (see top).
package seq_det_pkg;

    localparam int unsigned PAT_LEN_MIN = 2;
    localparam int unsigned PAT_LEN_MAX = 16;
    localparam int unsigned DEF_PAT_LEN = 4;
    localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 4'b1011;
    localparam int unsigned DEF_CNT_W   = 8;

    // Table entries must hold 0..PAT_LEN_MAX inclusive (PAT_LEN_MAX marks completion).
    localparam int unsigned STATE_W = 5;
    localparam int unsigned IDX_W   = $clog2(PAT_LEN_MAX);

    typedef logic [STATE_W-1:0] kval_t;
    typedef kval_t [PAT_LEN_MAX:0] fail_tab_t;
    typedef kval_t [PAT_LEN_MAX-1:0][1:0] next_tab_t;

    // Bit k of the pattern in arrival order (k = 0 is the MSB, received first).
    function automatic logic pat_bit(input logic [PAT_LEN_MAX-1:0] pat,
                                     input int unsigned len,
                                     input int unsigned k);
        return pat[IDX_W'(len - 1 - k)];
    endfunction

    // f[i] = length of the longest proper prefix of pattern[0..i-1] that is also its suffix.
    function automatic fail_tab_t seq_det_fail_table(input logic [PAT_LEN_MAX-1:0] pat,
                                                     input int unsigned len);
        fail_tab_t   f;
        int unsigned j;
        f = '0;
        j = 0;
        for (int unsigned i = 1; i < PAT_LEN_MAX; i++) begin
            if (i < len) begin
                for (int unsigned t = 0; t < PAT_LEN_MAX; t++) begin
                    if (j > 0 && pat_bit(pat, len, i) != pat_bit(pat, len, j)) begin
                        j = 32'(f[j]);
                    end
                end
                if (pat_bit(pat, len, i) == pat_bit(pat, len, j)) begin
                    j = j + 1;
                end
                f[i + 1] = kval_t'(j);
            end
        end
        return f;
    endfunction

    // n[k][b] = prefix length after receiving bit b in state k; value len means completion.
    function automatic next_tab_t seq_det_next_table(input logic [PAT_LEN_MAX-1:0] pat,
                                                     input int unsigned len);
        fail_tab_t   f;
        next_tab_t   n;
        int unsigned fk;
        f = seq_det_fail_table(pat, len);
        n = '0;
        for (int unsigned k = 0; k < PAT_LEN_MAX; k++) begin
            if (k < len) begin
                fk = 32'(f[k]);
                for (int unsigned b = 0; b < 2; b++) begin
                    if (pat_bit(pat, len, k) == 1'(b)) begin
                        n[k][b] = kval_t'(k + 1);
                    end else if (k == 0) begin
                        n[k][b] = '0;
                    end else begin
                        n[k][b] = n[fk][b];
                    end
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/seq_det_counter.sv
// Saturating match counter with async active-low reset and synchronous clear.
module seq_det_counter
    import seq_det_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/seq_detector_param.sv
// Parameterised serial pattern detector (KMP next-state table built at elaboration).
// Define SEQ_DET_COUNT_EN to instantiate the saturating match counter; otherwise match_cnt is 0.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned          PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0]   PATTERN = DEF_PATTERN,
    parameter int unsigned          CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seq,
    input  logic             seq_valid,
    input  logic             overlap_en,
    input  logic             clear,
    output logic             dout,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned K_W = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
    localparam logic [PAT_LEN_MAX-1:0] PAT_EXT = PAT_LEN_MAX'(PATTERN);
    localparam fail_tab_t FALLBACK_TAB = seq_det_fail_table(PAT_EXT, PAT_LEN);
    localparam next_tab_t NEXT_TAB     = seq_det_next_table(PAT_EXT, PAT_LEN);
    localparam logic [K_W-1:0] K_FULL  = K_W'(FALLBACK_TAB[PAT_LEN]);

    if (PAT_LEN < PAT_LEN_MIN || PAT_LEN > PAT_LEN_MAX) begin : g_bad_len
        $error("seq_detector_param: PAT_LEN out of range 2..16");
    end

    logic [K_W-1:0]   r_k;
    logic             r_dout;
    logic [K_W-1:0]   w_k_next;
    logic             w_dout_next;
    logic [IDX_W-1:0] w_k_idx;
    kval_t            w_step;
    logic             w_complete;

    assign w_k_idx    = IDX_W'(r_k);
    assign w_step     = NEXT_TAB[w_k_idx][seq];
    assign w_complete = seq_valid && (w_step == kval_t'(PAT_LEN));

    always_comb begin
        w_k_next    = r_k;
        w_dout_next = 1'b0;
        if (clear) begin
            w_k_next = '0;
        end else if (seq_valid) begin
            if (w_complete) begin
                w_dout_next = 1'b1;
                w_k_next    = overlap_en ? K_FULL : '0;
            end else begin
                w_k_next = K_W'(w_step);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_k    <= '0;
            r_dout <= 1'b0;
        end else begin
            r_k    <= w_k_next;
            r_dout <= w_dout_next;
        end
    end

    assign dout = r_dout;

`ifdef SEQ_DET_COUNT_EN
    // Counting on the dout-next term keeps match_cnt in step with the dout pulse.
    seq_det_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (w_dout_next),
        .count (match_cnt)
    );
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed, table-driven bench for seq_detector_param (PATTERN 1011) plus a CNT_W=2 instance.
module tb_seq_detector_param;
    import seq_det_pkg::*;

`ifdef SEQ_DET_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       seq = 1'b0, seq_valid = 1'b0, overlap_en = 1'b0, clear = 1'b0;
    logic       dout;
    logic [7:0] match_cnt;

    logic       s_seq = 1'b0, s_valid = 1'b0, s_clear = 1'b0;
    logic       s_dout;
    logic [1:0] s_cnt;

    int total = 0;
    int bad   = 0;

    always #100 clk = ~clk;

    seq_detector_param #(
        .PAT_LEN (4),
        .PATTERN (4'b1011),
        .CNT_W   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seq        (seq),
        .seq_valid  (seq_valid),
        .overlap_en (overlap_en),
        .clear      (clear),
        .dout       (dout),
        .match_cnt  (match_cnt)
    );

    seq_detector_param #(
        .PAT_LEN (4),
        .PATTERN (4'b1011),
        .CNT_W   (2)
    ) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .seq        (s_seq),
        .seq_valid  (s_valid),
        .overlap_en (1'b0),
        .clear      (s_clear),
        .dout       (s_dout),
        .match_cnt  (s_cnt)
    );

    typedef struct {
        logic  s, v, ov, clr;
        logic  exp_dout;
        int    exp_cnt;
        int    exp_k;
        string name;
    } vec_t;

    vec_t vecs[$];

    function automatic int cexp(input int c);
        return CNT_ON ? c : 0;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic v, input logic ov, input logic clr,
                       input logic d, input int c, input int k, input string nm);
        vec_t r;
        r.s = s; r.v = v; r.ov = ov; r.clr = clr;
        r.exp_dout = d; r.exp_cnt = c; r.exp_k = k; r.name = nm;
        vecs.push_back(r);
    endtask

    task automatic cyc(input logic s, input logic v, input logic ov, input logic clr);
        seq = s; seq_valid = v; overlap_en = ov; clear = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic scyc(input logic s, input logic v);
        s_seq = s; s_valid = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;

        // overlap, 1011011
        add(1,1,1,0, 0,0,1, "ov_b1");  add(0,1,1,0, 0,0,2, "ov_b2");
        add(1,1,1,0, 0,0,3, "ov_b3");  add(1,1,1,0, 1,1,1, "ov_b4");
        add(0,1,1,0, 0,1,2, "ov_b5");  add(1,1,1,0, 0,1,3, "ov_b6");
        add(1,1,1,0, 1,2,1, "ov_b7");
        add(0,0,1,1, 0,0,0, "clr1");
        // non-overlap, 1011011
        add(1,1,0,0, 0,0,1, "no_b1");  add(0,1,0,0, 0,0,2, "no_b2");
        add(1,1,0,0, 0,0,3, "no_b3");  add(1,1,0,0, 1,1,0, "no_b4");
        add(0,1,0,0, 0,1,0, "no_b5");  add(1,1,0,0, 0,1,1, "no_b6");
        add(1,1,0,0, 0,1,1, "no_b7");
        add(0,0,0,1, 0,0,0, "clr2");
        // valid gap inside a prefix
        add(1,1,1,0, 0,0,1, "gap_b1"); add(0,1,1,0, 0,0,2, "gap_b2");
        add(1,1,1,0, 0,0,3, "gap_b3");
        add(1,0,1,0, 0,0,3, "gap_i1"); add(1,0,1,0, 0,0,3, "gap_i2");
        add(1,0,1,0, 0,0,3, "gap_i3");
        add(1,1,1,0, 1,1,1, "gap_b4");
        add(0,0,1,1, 0,0,0, "clr3");
        // clear beats a completing bit
        add(1,1,1,0, 0,0,1, "cw_b1");  add(0,1,1,0, 0,0,2, "cw_b2");
        add(1,1,1,0, 0,0,3, "cw_b3");  add(1,1,1,1, 0,0,0, "cw_clr");
        // overlap_en changes mid-stream, mismatch fallbacks
        add(1,1,1,0, 0,0,1, "oc_b1");  add(0,1,0,0, 0,0,2, "oc_b2");
        add(1,1,0,0, 0,0,3, "oc_b3");  add(1,1,0,0, 1,1,0, "oc_b4");
        add(0,1,1,0, 0,1,0, "fb_0");   add(1,1,1,0, 0,1,1, "fb_1");
        add(1,1,1,0, 0,1,1, "fb_11");  add(0,1,1,0, 0,1,2, "fb_10");
        add(1,1,1,0, 0,1,3, "fb_101"); add(0,1,1,0, 0,1,2, "fb_1010");
        add(1,1,1,0, 0,1,3, "fb_b3");  add(1,1,1,0, 1,2,1, "fb_b4");

        // reset state
        #30;
        chk("rst_dout", int'(dout), 0);
        chk("rst_cnt",  int'(match_cnt), 0);
        chk("rst_k",    int'(dut.r_k), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            cyc(vecs[i].s, vecs[i].v, vecs[i].ov, vecs[i].clr);
            chk({vecs[i].name, "_dout"}, int'(dout), int'(vecs[i].exp_dout));
            chk({vecs[i].name, "_cnt"},  int'(match_cnt), cexp(vecs[i].exp_cnt));
            chk({vecs[i].name, "_k"},    int'(dut.r_k), vecs[i].exp_k);
        end

        // reset mid-pattern discards the prefix
        cyc(0, 1, 1, 0);
        cyc(1, 1, 1, 0);
        chk("mr_k_before", int'(dut.r_k), 3);
        seq_valid = 1'b0;
        #50;
        rst = 1'b0;
        #1;
        chk("mr_async_k",    int'(dut.r_k), 0);
        chk("mr_async_dout", int'(dout), 0);
        chk("mr_async_cnt",  int'(match_cnt), 0);
        #9;
        rst = 1'b1;
        cyc(0, 0, 1, 0);
        chk("mr_idle_k", int'(dut.r_k), 0);
        cyc(1, 1, 1, 0);
        chk("mr_b1_dout", int'(dout), 0);
        chk("mr_b1_k",    int'(dut.r_k), 1);
        cyc(0, 1, 1, 0);
        cyc(1, 1, 1, 0);
        cyc(1, 1, 1, 0);
        chk("mr_full_dout", int'(dout), 1);
        chk("mr_full_cnt",  int'(match_cnt), cexp(1));
        cyc(0, 0, 1, 0);
        chk("mr_pulse_end", int'(dout), 0);

        // CNT_W=2 saturation over five non-overlapping matches
        chk("sat_start", int'(s_cnt), 0);
        pulses = 0;
        for (int m = 0; m < 5; m++) begin
            scyc(1, 1); pulses += int'(s_dout);
            scyc(0, 1); pulses += int'(s_dout);
            scyc(1, 1); pulses += int'(s_dout);
            scyc(1, 1); pulses += int'(s_dout);
            chk($sformatf("sat_m%0d_dout", m), int'(s_dout), 1);
            chk($sformatf("sat_m%0d_cnt", m), int'(s_cnt), cexp((m + 1 > 3) ? 3 : m + 1));
        end
        scyc(0, 0);
        chk("sat_hold_dout", int'(s_dout), 0);
        chk("sat_hold_cnt",  int'(s_cnt), cexp(3));
        chk("sat_pulses", pulses, 5);
        s_clear = 1'b1;
        scyc(0, 0);
        s_clear = 1'b0;
        chk("sat_clear_cnt", int'(s_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter PAT_LEN, default 4: pattern length in bits; legal range 2..16.
REQ-002 Parameter PATTERN, default 4'b1011: target pattern, PAT_LEN bits wide; the MSB is the first bit received.
REQ-003 Parameter CNT_W, default 8: width of the match counter.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-low reset.
REQ-006 Port seq, input, 1: serial data bit.
REQ-007 Port seq_valid, input, 1: seq is sampled only when high.
REQ-008 Port overlap_en, input, 1: 1 = overlapping detection; 0 = non-overlapping detection.
REQ-009 Port clear, input, 1: synchronous clear of detector state and match counter.
REQ-010 Port dout, output, 1: registered one-cycle match pulse.
REQ-011 Port match_cnt, output, CNT_W: saturating count of detected matches.

Function
REQ-012 The detector state SHALL be the matched-prefix length k, with range 0..PAT_LEN-1.
REQ-013 On a valid bit equal to PATTERN bit k, with k < PAT_LEN-1, k SHALL advance to k+1.
REQ-014 On a valid mismatching bit, k SHALL fall back to the longest proper prefix of PATTERN that is also a suffix of the received history including the current bit (KMP failure rule), never losing an embedded partial match.
REQ-015 The failure/next-state table SHALL be computed at elaboration from PATTERN and PAT_LEN; no runtime pattern load.
REQ-016 On a valid bit completing the pattern (k = PAT_LEN-1, bit matches), dout SHALL be 1 in the following cycle only.
REQ-017 After a completing bit, k SHALL become the failure value of the full pattern when overlap_en=1, and 0 when overlap_en=0.
REQ-018 When seq_valid=0, k and match_cnt SHALL hold and dout SHALL be 0 in the next cycle.
REQ-019 clear=1 SHALL force k=0, match_cnt=0 and dout=0 at the next edge.
REQ-020 When clear and seq_valid are both 1, clear SHALL win and the bit SHALL be discarded.
REQ-021 match_cnt SHALL increment by 1 on each dout pulse and saturate at 2^CNT_W-1.
REQ-022 A change of overlap_en mid-stream SHALL affect only the next completion; it SHALL NOT reset k.

Reset
REQ-023 While rst=0, the block SHALL hold k=0, dout=0 and match_cnt=0, asynchronously.
REQ-024 On rst deassertion, detection SHALL start from k=0 with the first valid bit after the next rising edge.
REQ-025 A reset mid-pattern SHALL discard all partial-match history.

Configuration
REQ-026 Macro SEQ_DET_COUNT_EN defined: the match counter is instantiated per REQ-021.
REQ-027 Macro SEQ_DET_COUNT_EN undefined: the counter is omitted and match_cnt SHALL be constant 0; dout is unchanged.

Structure
REQ-028 Package seq_det_pkg SHALL hold PAT_LEN limits (MIN 2, MAX 16), the default PATTERN, the default CNT_W, and the failure-table computation function.
REQ-029 The saturating counter SHALL be the sub-module seq_det_counter (inputs: clk, rst, clear, inc; output: count).
REQ-030 All remaining logic (state register, next-state logic, dout register) SHALL live in seq_detector_param.

Verification (PATTERN=1011, PAT_LEN=4, clock period 200 ns, SEQ_DET_COUNT_EN defined)
REQ-031 overlap_en=1, valid bits 1011011 -> dout pulses after bit 4 and after bit 7; match_cnt=2.
REQ-032 overlap_en=0, valid bits 1011011 -> dout pulses after bit 4 only; match_cnt=1; k=1 at end.
REQ-033 Bits 1,0,1 then seq_valid=0 for 3 cycles, then bit 1 -> no dout during the gap; dout pulses after the final 1.
REQ-034 Bits 1,0,1, then rst=0 for 10 ns, then bit 1 -> no dout; k=1 afterwards.
REQ-035 clear=1 together with a valid completing bit -> no dout; match_cnt=0; k=0.
REQ-036 CNT_W=2, 5 non-overlapping matches -> match_cnt saturates at 3; dout pulses 5 times.
